// File: rtl/multicycle_control.sv
`timescale 1ns/1ps
// multicycle_control
// Moore-style sequencer for the multicycle RV32I core (lw, sw, beq, R-type).
// It shares one ALU and one unified instruction/data memory across fetch,
// decode, execute, memory and writeback steps. Each memory access waits for
// mem_ready. Only the fetch PC/IR writes and the store retire are qualified
// combinationally by mem_ready; every other output is a pure function of the
// state register. While rst is high, all outputs are held at 0 so that an
// abandoned instruction cannot commit anything in the reset cycle.
module multicycle_control (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       PCSource,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic       retire,
  output logic       illegal_op
);

  // Supported major opcodes (IR[6:0]).
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_R   = 7'b0110011;

  // ALU input A select.
  localparam logic [1:0] SRCA_PC     = 2'b00;
  localparam logic [1:0] SRCA_OLD_PC = 2'b01;
  localparam logic [1:0] SRCA_REG_A  = 2'b10;

  // ALU input B select.
  localparam logic [1:0] SRCB_REG_B  = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;

  // ALU operation.
  localparam logic [1:0] ALU_ADD     = 2'b00;
  localparam logic [1:0] ALU_SUB     = 2'b01;
  localparam logic [1:0] ALU_FUNCT   = 2'b10;

  typedef enum logic [3:0] {
    ST_FETCH,
    ST_DECODE,
    ST_MEMADR,
    ST_MEMREAD,
    ST_MEMWB,
    ST_MEMWRITE,
    ST_EXECUTE,
    ST_ALUWB,
    ST_BRANCH
  } state_t;

  // Bundled control word. The field order matches the output concatenation
  // below, so one zero assignment clears every output at once.
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       pc_source;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       retire;
    logic       illegal_op;
  } ctrl_t;

  state_t state;
  state_t state_next;
  ctrl_t  ctrl;
  logic   op_legal;

  // Flag opcodes that belong to the supported subset.
  always_comb begin
    case (opcode)
      OP_LW, OP_SW, OP_BEQ, OP_R: op_legal = 1'b1;
      default:                    op_legal = 1'b0;
    endcase
  end

  // State register with synchronous reset back to FETCH.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignment so every flop samples pre-edge values.
    if (rst) begin
      state <= ST_FETCH;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. opcode is consulted only in DECODE and MEMADR.
  always_comb begin
    // NOTE: default first so no path leaves state_next unassigned, which would infer a latch.
    state_next = state;
    case (state)
      ST_FETCH: begin
        if (mem_ready) state_next = ST_DECODE;
      end
      ST_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_next = ST_MEMADR;
          OP_R:         state_next = ST_EXECUTE;
          OP_BEQ:       state_next = ST_BRANCH;
          default:      state_next = ST_FETCH;
        endcase
      end
      ST_MEMADR: begin
        if (opcode == OP_LW) begin
          state_next = ST_MEMREAD;
        end else if (opcode == OP_SW) begin
          state_next = ST_MEMWRITE;
        end else begin
          // Unreachable while IR is stable. Drop back to a clean fetch.
          state_next = ST_FETCH;
        end
      end
      ST_MEMREAD: begin
        if (mem_ready) state_next = ST_MEMWB;
      end
      ST_MEMWB:    state_next = ST_FETCH;
      ST_MEMWRITE: begin
        if (mem_ready) state_next = ST_FETCH;
      end
      ST_EXECUTE:  state_next = ST_ALUWB;
      ST_ALUWB:    state_next = ST_FETCH;
      ST_BRANCH:   state_next = ST_FETCH;
      default:     state_next = ST_FETCH;
    endcase
  end

  // Output decode. Outputs are zero in reset and whenever a state leaves them unset.
  always_comb begin
    ctrl = '0;
    if (!rst) begin
      case (state)
        ST_FETCH: begin
          // PC+4 goes straight back into the PC as the instruction word lands in IR.
          ctrl.iord      = 1'b0;
          ctrl.mem_read  = 1'b1;
          ctrl.alu_src_a = SRCA_PC;
          ctrl.alu_src_b = SRCB_FOUR;
          ctrl.alu_op    = ALU_ADD;
          ctrl.pc_source = 1'b0;
          ctrl.ir_write  = mem_ready;
          ctrl.pc_write  = mem_ready;
        end
        ST_DECODE: begin
          // Branch target (OldPC + imm) is computed speculatively into ALUOut.
          ctrl.alu_src_a  = SRCA_OLD_PC;
          ctrl.alu_src_b  = SRCB_IMM;
          ctrl.alu_op     = ALU_ADD;
          ctrl.illegal_op = !op_legal;
        end
        ST_MEMADR: begin
          ctrl.alu_src_a = SRCA_REG_A;
          ctrl.alu_src_b = SRCB_IMM;
          ctrl.alu_op    = ALU_ADD;
        end
        ST_MEMREAD: begin
          ctrl.iord     = 1'b1;
          ctrl.mem_read = 1'b1;
        end
        ST_MEMWB: begin
          ctrl.mem_to_reg = 1'b1;
          ctrl.reg_write  = 1'b1;
          ctrl.retire     = 1'b1;
        end
        ST_MEMWRITE: begin
          // The request is held steady through the wait. The store retires on
          // the cycle the memory accepts it.
          ctrl.iord      = 1'b1;
          ctrl.mem_write = 1'b1;
          ctrl.retire    = mem_ready;
        end
        ST_EXECUTE: begin
          ctrl.alu_src_a = SRCA_REG_A;
          ctrl.alu_src_b = SRCB_REG_B;
          ctrl.alu_op    = ALU_FUNCT;
        end
        ST_ALUWB: begin
          ctrl.mem_to_reg = 1'b0;
          ctrl.reg_write  = 1'b1;
          ctrl.retire     = 1'b1;
        end
        ST_BRANCH: begin
          // The datapath ANDs PCWriteCond with zero. The taken target comes from ALUOut.
          ctrl.alu_src_a     = SRCA_REG_A;
          ctrl.alu_src_b     = SRCB_REG_B;
          ctrl.alu_op        = ALU_SUB;
          ctrl.pc_write_cond = 1'b1;
          ctrl.pc_source     = 1'b1;
          ctrl.retire        = 1'b1;
        end
        default: ctrl = '0;
      endcase
    end
  end

  assign {PCWrite, PCWriteCond, PCSource, IorD, MemRead, MemWrite, IRWrite,
          MemtoReg, RegWrite, ALUSrcA, ALUSrcB, ALUOp, retire, illegal_op} = ctrl;

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Moore-style control FSM for the multicycle RV32I core, covering the same instruction subset as the single-cycle `control` decoder: lw, sw, beq and R-type. It sequences one shared ALU and one unified instruction/data memory across fetch, decode, execute, memory and writeback states. Each memory access waits on a `mem_ready` handshake. It drives all datapath mux selects and write enables, and flags retirement and illegal opcodes.

## Interface
- No parameters. State encoding is internal; an enumeration is recommended.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- opcode  in  7  IR[6:0]; stable from the cycle after IR is written
- mem_ready  in  1  memory completes the current access this cycle
- PCWrite  out  1  unconditional PC write
- PCWriteCond  out  1  PC write when ALU zero flag is 1 (beq)
- PCSource  out  1  PC source: 0 = ALU result, 1 = ALUOut register
- IorD  out  1  memory address: 0 = PC, 1 = ALUOut
- MemRead  out  1  memory read request, held until mem_ready
- MemWrite  out  1  memory write request, held until mem_ready
- IRWrite  out  1  IR and OldPC load
- MemtoReg  out  1  register write data: 0 = ALUOut, 1 = MDR
- RegWrite  out  1  register file write
- ALUSrcA  out  2  ALU A input: 00 = PC, 01 = OldPC, 10 = register A
- ALUSrcB  out  2  ALU B input: 00 = register B, 01 = constant 4, 10 = immediate
- ALUOp  out  2  ALU operation: 00 = add, 01 = sub, 10 = decode from funct
- retire  out  1  one-cycle pulse when an instruction completes
- illegal_op  out  1  one-cycle pulse when an unsupported opcode is decoded

## Operation
- Opcodes: LW 0000011, SW 0100011, BEQ 1100011, R 0110011. All other opcodes are illegal.
- Unlisted outputs are 0 in every state.
- FETCH:
  - Drives IorD=0, MemRead=1, ALUSrcA=00, ALUSrcB=01, ALUOp=00.
  - IRWrite = PCWrite = mem_ready, with PCSource=0.
  - Goes to DECODE on mem_ready; otherwise stays in FETCH.
- DECODE:
  - Drives ALUSrcA=01, ALUSrcB=10, ALUOp=00, so the branch target is computed into ALUOut.
  - Next state: LW/SW → MEMADR, R → EXECUTE, BEQ → BRANCH.
  - Illegal opcode: illegal_op=1 for this cycle, then FETCH. No architectural state changes.
- MEMADR: drives ALUSrcA=10, ALUSrcB=10, ALUOp=00. Goes to MEMREAD if opcode is LW, MEMWRITE if SW.
- MEMREAD: drives IorD=1, MemRead=1. Goes to MEMWB on mem_ready; otherwise holds.
- MEMWB: drives MemtoReg=1, RegWrite=1, retire=1, then FETCH.
- MEMWRITE: drives IorD=1, MemWrite=1, retire=mem_ready. Goes to FETCH on mem_ready; otherwise holds.
- EXECUTE: drives ALUSrcA=10, ALUSrcB=00, ALUOp=10, then ALUWB.
- ALUWB: drives MemtoReg=0, RegWrite=1, retire=1, then FETCH.
- BRANCH:
  - Drives ALUSrcA=10, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=1, retire=1, then FETCH.
  - The taken/not-taken decision is made in the datapath (PCWriteCond AND zero).
- MemRead and MemWrite are never both 1. Request outputs remain constant while waiting on mem_ready.
- After DECODE, opcode is read only in MEMADR. IR does not change outside FETCH.

## Timing
- The state register updates on the rising edge of clk. Outputs are a combinational function of the state register, plus mem_ready for the qualified signals (IRWrite, PCWrite, retire in MEMWRITE).
- Reset:
  - rst sampled high → state = FETCH on that edge.
  - While rst is high, every output is forced to 0, including MemRead.
  - The first cycle after rst falls is FETCH with MemRead=1.
- Reset mid-operation (including during a pending memory wait) abandons the instruction. No RegWrite, PCWrite or MemWrite is asserted in the reset cycle.
- Latency with zero-wait memory (mem_ready always 1):
  - lw 5 cycles, sw 4, R-type 4, beq 3, illegal 2.
- Each cycle with mem_ready=0 in FETCH, MEMREAD or MEMWRITE adds exactly one cycle.
- mem_ready is ignored in every other state.
- retire asserts at most once per instruction, in its final cycle. illegal_op and retire are never both 1.

## Test plan
- Reset with mem_ready=1:
  - All outputs 0 during rst.
  - The cycle after release: MemRead=1, IRWrite=1, PCWrite=1, ALUSrcB=01.
- lw (0000011) with mem_ready=1: state sequence FETCH, DECODE, MEMADR, MEMREAD, MEMWB. RegWrite=1 and MemtoReg=1 in cycle 5; retire pulses exactly once.
- sw (0100011) with mem_ready low for 3 cycles in MEMWRITE:
  - MemWrite=1 and IorD=1 are held stable for 4 cycles.
  - retire pulses only in the cycle where mem_ready=1. Total latency 7.
- R (0110011) and beq (1100011):
  - R-type: EXECUTE drives ALUOp=10, then ALUWB drives RegWrite=1.
  - beq: BRANCH drives ALUOp=01, PCWriteCond=1, PCSource=1. Latencies 4 and 3.
- Sweep all 128 opcodes: every opcode outside the four legal ones gives illegal_op=1 in DECODE, then FETCH, with no RegWrite, MemWrite or retire.
- rst asserted during MEMREAD while mem_ready=0: the next state is FETCH, and RegWrite is never asserted for the abandoned lw.
